// File: rtl/shift_exec_if.sv
// ---------------------------------------------------------------------------
// shift_exec_if
//   Issue-side and writeback-side handshake bundle for shift_exec_stage.
//
//   Issue channel (master drives, stage consumes):
//     in_valid, in_op[1:0], in_a[31:0], in_b[31:0], in_rd[TAG_W-1:0]
//     in_ready    (driven back by the stage)
//   Writeback channel (stage drives, master consumes):
//     out_valid, out_result[31:0], out_rd[TAG_W-1:0], out_zero
//     out_ready   (driven by writeback)
//
//   modport slave  : the execute stage
//   modport master : issue logic + writeback (or a testbench)
// ---------------------------------------------------------------------------
interface shift_exec_if #(
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [31:0]      in_a;
    logic [31:0]      in_b;
    logic [TAG_W-1:0] in_rd;

    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_result;
    logic [TAG_W-1:0] out_rd;
    logic             out_zero;

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_rd, out_ready,
        output in_ready, out_valid, out_result, out_rd, out_zero
    );

    modport master (
        output in_valid, in_op, in_a, in_b, in_rd, out_ready,
        input  in_ready, out_valid, out_result, out_rd, out_zero
    );
endinterface

// File: rtl/shift_exec_stage.sv
// ---------------------------------------------------------------------------
// shift_exec_stage
//   Two-stage execute pipeline for 32-bit shifts.
//     S1 : registers op, operand a, shift amount (in_b[4:0]) and dest tag.
//     S2 : registers the op-selected shifter result, its zero flag and tag.
//   Full throughput (one op per clock), valid/ready backpressure on both
//   sides, synchronous flush that empties both stages.
//
//   Ports:
//     clk    : clock, rising edge
//     rst_n  : asynchronous active-low reset
//     flush  : synchronous kill of everything in flight
//     bus    : shift_exec_if.slave (issue + writeback handshakes)
//
//   Ops: 00 SLL, 01 SRL, 10 SRA, 11 ROR (if SHIFT_ROTATE_EN) else reserved.
//   Build option: define SHIFT_ROTATE_EN to make op 11 rotate right; when
//   undefined, op 11 produces 0 (zero flag set) with normal flow.
// ---------------------------------------------------------------------------
module shift_exec_stage #(
    parameter int TAG_W = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    shift_exec_if.slave bus
);
    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;

    // ---------------- pipeline state ----------------
    logic             s1_valid_q, s1_valid_d;
    logic [1:0]       s1_op_q,    s1_op_d;
    logic [31:0]      s1_a_q,     s1_a_d;
    logic [4:0]       s1_shamt_q, s1_shamt_d;
    logic [TAG_W-1:0] s1_rd_q,    s1_rd_d;

    logic             s2_valid_q,  s2_valid_d;
    logic [31:0]      s2_result_q, s2_result_d;
    logic             s2_zero_q,   s2_zero_d;
    logic [TAG_W-1:0] s2_rd_q,     s2_rd_d;

    logic adv1;
    logic adv2;
    logic in_fire;

    // Upper shift-amount bits are architecturally ignored.
    logic unused_b_hi;
    assign unused_b_hi = ^bus.in_b[31:5];

    // A stage may take new data when it is empty or its content moves on.
    assign adv2        = ~s2_valid_q | bus.out_ready;
    assign adv1        = ~s1_valid_q | adv2;
    assign bus.in_ready = adv1 & ~flush & rst_n;
    assign in_fire     = bus.in_valid & bus.in_ready;

    // ---------------- shifters ----------------
    // Log-depth barrel shifters: stage gi shifts by 2**gi when shamt[gi] set.
    logic [31:0] sll_st [0:5];
    logic [31:0] srl_st [0:5];
    logic [31:0] sra_st [0:5];

    assign sll_st[0] = s1_a_q;
    assign srl_st[0] = s1_a_q;
    assign sra_st[0] = s1_a_q;

    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_shift
            localparam int SH = 1 << gi;
            assign sll_st[gi+1] = s1_shamt_q[gi] ? {sll_st[gi][31-SH:0], {SH{1'b0}}}
                                                 : sll_st[gi];
            assign srl_st[gi+1] = s1_shamt_q[gi] ? {{SH{1'b0}}, srl_st[gi][31:SH]}
                                                 : srl_st[gi];
            // Fill with the original sign bit so every stage stays arithmetic.
            assign sra_st[gi+1] = s1_shamt_q[gi] ? {{SH{s1_a_q[31]}}, sra_st[gi][31:SH]}
                                                 : sra_st[gi];
        end
    endgenerate

`ifdef SHIFT_ROTATE_EN
    // Rotating stages realise srl(a,s) | sll(a,(32-s)&31); shamt=0 passes a
    // straight through, which is the required gating.
    logic [31:0] ror_st [0:5];
    assign ror_st[0] = s1_a_q;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_rot
            localparam int SH = 1 << gi;
            assign ror_st[gi+1] = s1_shamt_q[gi] ? {ror_st[gi][SH-1:0], ror_st[gi][31:SH]}
                                                 : ror_st[gi];
        end
    endgenerate
`endif

    logic [31:0] shift_res;
    always_comb begin
        shift_res = 32'h0;
        unique case (s1_op_q)
            OP_SLL:  shift_res = sll_st[5];
            OP_SRL:  shift_res = srl_st[5];
            OP_SRA:  shift_res = sra_st[5];
`ifdef SHIFT_ROTATE_EN
            default: shift_res = ror_st[5];
`else
            default: shift_res = 32'h0;     // reserved op
`endif
        endcase
    end

    // ---------------- next-state ----------------
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_op_d     = s1_op_q;
        s1_a_d      = s1_a_q;
        s1_shamt_d  = s1_shamt_q;
        s1_rd_d     = s1_rd_q;
        s2_valid_d  = s2_valid_q;
        s2_result_d = s2_result_q;
        s2_zero_d   = s2_zero_q;
        s2_rd_d     = s2_rd_q;

        // S1 data
        if (in_fire) begin
            s1_op_d    = bus.in_op;
            s1_a_d     = bus.in_a;
            s1_shamt_d = bus.in_b[4:0];
            s1_rd_d    = bus.in_rd;
        end

        // S2 data
        if (s1_valid_q && adv2) begin
            s2_result_d = shift_res;
            s2_zero_d   = (shift_res == 32'h0);
            s2_rd_d     = s1_rd_q;
        end

        // Valid bits; flush wins over everything (data may go stale).
        if (flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end else begin
            if (adv1) s1_valid_d = in_fire;
            if (adv2) s2_valid_d = s1_valid_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_op_q     <= 2'b00;
            s1_a_q      <= 32'h0;
            s1_shamt_q  <= 5'd0;
            s1_rd_q     <= '0;
            s2_valid_q  <= 1'b0;
            s2_result_q <= 32'h0;
            s2_zero_q   <= 1'b0;
            s2_rd_q     <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_op_q     <= s1_op_d;
            s1_a_q      <= s1_a_d;
            s1_shamt_q  <= s1_shamt_d;
            s1_rd_q     <= s1_rd_d;
            s2_valid_q  <= s2_valid_d;
            s2_result_q <= s2_result_d;
            s2_zero_q   <= s2_zero_d;
            s2_rd_q     <= s2_rd_d;
        end
    end

    assign bus.out_valid  = s2_valid_q;
    assign bus.out_result = s2_result_q;
    assign bus.out_rd     = s2_rd_q;
    assign bus.out_zero   = s2_zero_q;
endmodule

// File: tb/tb_shift_exec_stage.sv
// ---------------------------------------------------------------------------
// tb_shift_exec_stage
//   Directed cases followed by randomized traffic, checked against a
//   queue-based reference of ops in flight.
// ---------------------------------------------------------------------------
module tb_shift_exec_stage;
    logic clk = 1'b0;
    logic rst_n;
    logic flush;

    shift_exec_if #(.TAG_W(5)) bus ();

    shift_exec_stage #(.TAG_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   acc_cnt  = 0;
    int   out_cnt  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    endtask

    // Reference shift semantics from plain arithmetic.
    function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        int          s;
        logic [63:0] p;
        logic [63:0] aa;
        s  = int'(b % 32);
        p  = 64'd1 << s;
        case (op)
            2'd0: ref_shift = 32'(({32'h0, a} * p) % 64'h1_0000_0000);
            2'd1: ref_shift = 32'({32'h0, a} / p);
            2'd2: ref_shift = a[31] ? ~32'({32'h0, ~a} / p) : 32'({32'h0, a} / p);
            default: begin
`ifdef SHIFT_ROTATE_EN
                aa = {a, a};
                ref_shift = 32'((aa / p) % 64'h1_0000_0000);
`else
                aa = 64'h0;
                ref_shift = 32'h0;
`endif
            end
        endcase
    endfunction

    // One clock: called just after a falling edge, returns just after the next.
    task automatic step(input logic v, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic ordy, input logic fl);
        logic exp_rdy, exp_ov, fire_in, fire_out;
        bus.in_valid  = v;
        bus.in_op     = op;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_rd     = rd;
        bus.out_ready = ordy;
        flush         = fl;
        #1;
        exp_rdy = !fl && (q.size() < 2 || ordy);
        exp_ov  = (q.size() > 0) && (cyc >= q[0].cyc + 1);
        check("in_ready", {31'h0, bus.in_ready}, {31'h0, exp_rdy});
        check("out_valid", {31'h0, bus.out_valid}, {31'h0, exp_ov});
        if (exp_ov && bus.out_valid) begin
            check("out_result", bus.out_result, q[0].res);
            check("out_rd", {27'h0, bus.out_rd}, {27'h0, q[0].rd});
            check("out_zero", {31'h0, bus.out_zero}, {31'h0, (q[0].res == 32'h0)});
        end
        fire_in  = v && bus.in_ready;
        fire_out = bus.out_valid && ordy;
        @(posedge clk);
        cyc++;
        if (fl) begin
            q.delete();
        end else begin
            if (fire_out && q.size() > 0) begin
                void'(q.pop_front());
                out_cnt++;
            end
            if (fire_in) begin
                q.push_back('{res: ref_shift(op, a, b), rd: rd, cyc: cyc});
                acc_cnt++;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 2'd0, 32'h0, 32'h0, 5'd0, ordy, 1'b0);
    endtask

    // Issue one op into an empty pipe and check its result against a constant.
    task automatic run_one(input string tag, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] rd,
                           input logic [31:0] exp_res);
        step(1'b1, op, a, b, rd, 1'b1, 1'b0);
        idle(1'b0);
        check({tag, "_valid"}, {31'h0, bus.out_valid}, 32'h1);
        check({tag, "_res"}, bus.out_result, exp_res);
        check({tag, "_zero"}, {31'h0, bus.out_zero}, {31'h0, (exp_res == 32'h0)});
        check({tag, "_rd"}, {27'h0, bus.out_rd}, {27'h0, rd});
        idle(1'b1);
    endtask

    initial begin
        int a0, o0;
        rst_n         = 1'b0;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_op     = 2'd0;
        bus.in_a      = 32'h0;
        bus.in_b      = 32'h0;
        bus.in_rd     = 5'd0;
        bus.out_ready = 1'b0;

        // 1: reset for 3 clocks
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", {31'h0, bus.in_ready}, 32'h0);
        check("rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
        rst_n = 1'b1;
        #1;
        check("rel_out_valid", {31'h0, bus.out_valid}, 32'h0);
        check("rel_out_result", bus.out_result, 32'h0);
        check("rel_out_zero", {31'h0, bus.out_zero}, 32'h0);
        check("rel_out_rd", {27'h0, bus.out_rd}, 32'h0);
        check("rel_in_ready", {31'h0, bus.in_ready}, 32'h1);

        // 2, 3: directed shifts
        run_one("sll31", 2'd0, 32'h0000_0001, 32'd31, 5'd1, 32'h8000_0000);
        run_one("sra4",  2'd2, 32'h8000_0000, 32'hFFFF_FFE4, 5'd2, 32'hF800_0000);
        run_one("srl31", 2'd1, 32'hFFFF_FFFF, 32'd31, 5'd3, 32'h0000_0001);
        run_one("srl0",  2'd1, 32'hFFFF_FFFF, 32'd0, 5'd4, 32'hFFFF_FFFF);
        run_one("sll0",  2'd0, 32'h1234_5678, 32'h0000_0020, 5'd5, 32'h1234_5678);

        // 4: backpressure, three back-to-back ops
        a0 = acc_cnt;
        o0 = out_cnt;
        step(1'b1, 2'd0, 32'h0000_000F, 32'd4, 5'd10, 1'b0, 1'b0);
        step(1'b1, 2'd1, 32'hF000_0000, 32'd8, 5'd11, 1'b0, 1'b0);
        step(1'b1, 2'd2, 32'h8000_0001, 32'd1, 5'd12, 1'b0, 1'b0);
        check("bp_accepted", 32'(acc_cnt - a0), 32'd2);
        check("bp_in_ready", {31'h0, bus.in_ready}, 32'h0);
        step(1'b1, 2'd2, 32'h8000_0001, 32'd1, 5'd12, 1'b1, 1'b0);
        repeat (3) idle(1'b1);
        check("bp_drained", 32'(out_cnt - o0), 32'd3);

        // 5: flush with two ops in flight
        o0 = out_cnt;
        step(1'b1, 2'd0, 32'h1, 32'd1, 5'd20, 1'b0, 1'b0);
        step(1'b1, 2'd0, 32'h2, 32'd1, 5'd21, 1'b0, 1'b0);
        a0 = acc_cnt;
        step(1'b1, 2'd0, 32'h3, 32'd1, 5'd22, 1'b0, 1'b1);
        check("fl_not_acc", 32'(acc_cnt - a0), 32'd0);
        check("fl_out_valid", {31'h0, bus.out_valid}, 32'h0);
        repeat (3) idle(1'b1);
        check("fl_no_output", 32'(out_cnt - o0), 32'd0);

        // 6: op 11
`ifdef SHIFT_ROTATE_EN
        run_one("op11", 2'd3, 32'h0000_0001, 32'd1, 5'd6, 32'h8000_0000);
`else
        run_one("op11", 2'd3, 32'h0000_0001, 32'd1, 5'd6, 32'h0000_0000);
`endif

        // Randomized traffic, with one mid-run reset.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] rb, ra;
            logic [4:0]  rrd;
            logic [1:0]  rop;
            rb  = $urandom;
            ra  = $urandom;
            rrd = 5'($urandom);
            rop = 2'($urandom);
            case ($urandom_range(0, 7))
                0: rb[4:0] = 5'd0;
                1: rb[4:0] = 5'd31;
                2: ra = 32'h0;
                default: ;
            endcase
            if (i == 1500) begin
                rst_n = 1'b0;
                bus.in_valid = 1'b0;
                #1;
                check("mid_rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
                check("mid_rst_in_ready", {31'h0, bus.in_ready}, 32'h0);
                q.delete();
                @(posedge clk);
                cyc++;
                @(negedge clk);
                rst_n = 1'b1;
            end
            step(($urandom_range(0, 9) < 7), rop, ra, rb, rrd,
                 ($urandom_range(0, 9) < 7), ($urandom_range(0, 39) == 0));
        end
        repeat (4) idle(1'b1);
        check("final_empty", 32'(q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
